audio_i2s_tx: RTL



---
 rtl/audio_pkg.sv | 18 +
 rtl/i2s_clk_gen.sv | 47 ++++
 rtl/audio_i2s_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types, default sizes and parameter sanity check
package audio_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int SLOT_WIDTH = 32;
    localparam int SCLK_HALF  = 8;
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // Slots must hold a whole sample and each SCLK phase needs at least two clk cycles
    function automatic bit params_ok(input int dw, input int sw, input int sh);
        return (sw >= dw) && (sh >= 2);
    endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: SCLK divider, frame bit position counter and LRCK decode
module i2s_clk_gen #(
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_HALF  = 8
) (
    input  logic clk,
    input  logic reset_n,
    output logic sclk,
    output logic lrck,
    output logic strobe,
    output logic frame_load
);
    localparam int FB = 2 * SLOT_WIDTH;
    localparam int CW = $clog2(SCLK_HALF);
    localparam int PW = $clog2(FB);

    logic [CW-1:0] cnt;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nxt;
    logic          wrap;

    // The falling SCLK toggle is the bit strobe; frame_load marks the strobe that enters p=0
    always_comb begin
        wrap       = cnt == CW'(SCLK_HALF - 1);
        strobe     = wrap && sclk;
        pos_nxt    = (pos == PW'(FB - 1)) ? '0 : pos + 1'b1;
        frame_load = strobe && (pos_nxt == '0);
    end

    // Divider, SCLK and position registers; LRCK leads each slot by one SCLK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
            pos  <= PW'(FB - 1);
            lrck <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                sclk <= ~sclk;
            if (strobe) begin
                pos  <= pos_nxt;
                lrck <= (pos_nxt >= PW'(SLOT_WIDTH - 1)) && (pos_nxt <= PW'(FB - 2));
            end
        end
    end
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo PCM to I2S serialiser with a one-pair holding buffer
module audio_i2s_tx #(
    parameter int DATA_WIDTH = audio_pkg::DATA_WIDTH,
    parameter int SLOT_WIDTH = audio_pkg::SLOT_WIDTH,
    parameter int SCLK_HALF  = audio_pkg::SCLK_HALF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] din_l,
    input  logic signed [DATA_WIDTH-1:0] din_r,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         i2s_sclk,
    output logic                         i2s_lrck,
    output logic                         i2s_sdata,
    output logic                         frame_start,
    output logic                         underrun
);
    import audio_pkg::*;

    localparam int FB = 2 * SLOT_WIDTH;

    if (!params_ok(DATA_WIDTH, SLOT_WIDTH, SCLK_HALF)) begin : g_bad_params
        $error("audio_i2s_tx: need SLOT_WIDTH >= DATA_WIDTH and SCLK_HALF >= 2");
    end

    logic [DATA_WIDTH-1:0] buf_l;
    logic [DATA_WIDTH-1:0] buf_r;
    logic                  full;
    logic                  full_nxt;
    logic                  accept;
    logic                  strobe;
    logic                  frame_load;
    logic [FB-1:0]         word;
    logic [FB-1:0]         shreg;

    i2s_clk_gen #(
        .SLOT_WIDTH(SLOT_WIDTH),
        .SCLK_HALF (SCLK_HALF)
    ) u_clk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (i2s_sclk),
        .lrck      (i2s_lrck),
        .strobe    (strobe),
        .frame_load(frame_load)
    );

    // A load sees the buffer as it was before this edge, so a same-cycle accept waits a frame
    always_comb begin
        accept   = in_valid && in_ready;
        full_nxt = accept || (full && !frame_load);
        word     = full ? ((FB'(buf_l) << (FB - DATA_WIDTH)) | (FB'(buf_r) << (SLOT_WIDTH - DATA_WIDTH))) : '0;
    end

    // Holding buffer, handshake, frame shift register and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full        <= 1'b0;
            in_ready    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            shreg       <= '0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            full        <= full_nxt;
            in_ready    <= !full_nxt;
            frame_start <= frame_load;
            underrun    <= frame_load && !full;
            if (accept) begin
                buf_l <= din_l;
                buf_r <= din_r;
            end
            if (frame_load) begin
                shreg     <= word << 1;
                i2s_sdata <= word[FB-1];
            end else if (strobe) begin
                shreg     <= shreg << 1;
                i2s_sdata <= shreg[FB-1];
            end
        end
    end
endmodule
